// File: rtl/dht11_frame_reader.sv
// DHT11 single-wire protocol engine: host start pulse, sensor response tracking, 40-bit frame capture.
// Optional macro DHT_GUARD_EN enforces a GUARD_MS quiet interval after each transaction and after reset.
module dht11_frame_reader #(
    parameter int unsigned CLK_HZ        = 25000000,
    parameter int unsigned START_LOW_US  = 18000,
    parameter int unsigned BIT_THRESH_US = 50,
    parameter int unsigned TIMEOUT_US    = 255,
    parameter int unsigned GUARD_MS      = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dht_in,
    output logic        dht_oe,
    output logic        busy,
    output logic        data_valid,
    output logic [39:0] frame,
    output logic [7:0]  hum_int,
    output logic [7:0]  hum_dec,
    output logic [7:0]  tmp_int,
    output logic [7:0]  tmp_dec,
    output logic        checksum_ok,
    output logic        error
);

    localparam int unsigned TICK_DIV = CLK_HZ / 1000000;
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned BCNT_W   = 6;
    localparam int unsigned N_BITS   = 40;

    if ((CLK_HZ % 1000000) != 0 || CLK_HZ < 1000000 || GUARD_MS == 0) begin : g_bad_cfg
        $error("dht11_frame_reader: CLK_HZ must be a nonzero multiple of 1 MHz and GUARD_MS nonzero");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_LOW,
        S_WAIT_ACK,
        S_ACK_LOW,
        S_ACK_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_DONE,
        S_ERR
    } state_t;

    state_t             r_state;
    logic [PRE_W-1:0]   r_pre;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCNT_W-1:0]  r_bit_cnt;
    logic [N_BITS-1:0]  r_shift;
    logic [1:0]         r_sync;
    logic               r_line_d;
    logic               r_oe;
    logic               r_busy;
    logic               r_valid;
    logic               r_error;
    logic [39:0]        r_frame;
    logic [7:0]         r_hum_int;
    logic [7:0]         r_hum_dec;
    logic [7:0]         r_tmp_int;
    logic [7:0]         r_tmp_dec;
    logic               r_csum_ok;

    logic               w_us_tick;
    logic               w_line;
    logic               w_rise;
    logic               w_fall;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_cnt_now;
    logic               w_timeout;
    logic               w_bit;
    logic [7:0]         w_sum;
    logic               w_guard_run;

    // Free-running microsecond prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
        end else if (r_pre == PRE_W'(TICK_DIV - 1)) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    assign w_us_tick = (r_pre == PRE_W'(TICK_DIV - 1));

    // Two-flop synchroniser plus one delay flop for edge detection; idle line is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= 2'b11;
            r_line_d <= 1'b1;
        end else begin
            r_sync   <= {r_sync[0], dht_in};
            r_line_d <= r_sync[1];
        end
    end

    assign w_line = r_sync[1];
    assign w_rise = w_line & ~r_line_d;
    assign w_fall = ~w_line & r_line_d;

    // Phase length including the tick of the current cycle, so an N-us phase reads as N
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_cnt_now = w_us_tick ? w_cnt_inc : r_cnt;
    assign w_timeout = (w_cnt_now > CNT_W'(TIMEOUT_US));
    assign w_bit     = (w_cnt_now > CNT_W'(BIT_THRESH_US));
    assign w_sum     = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];

`ifdef DHT_GUARD_EN
    localparam int unsigned GUARD_US = GUARD_MS * 1000;
    localparam logic        GUARD_ON = 1'b1;

    logic [31:0] r_guard_cnt;
    logic        r_guard_run;

    // Guard interval restarts on every transaction exit and on reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_guard_cnt <= '0;
            r_guard_run <= 1'b1;
        end else if (r_state == S_DONE || r_state == S_ERR) begin
            r_guard_cnt <= '0;
            r_guard_run <= 1'b1;
        end else if (r_guard_run && w_us_tick) begin
            if (r_guard_cnt == 32'(GUARD_US - 1)) begin
                r_guard_run <= 1'b0;
            end else begin
                r_guard_cnt <= r_guard_cnt + 32'd1;
            end
        end
    end

    assign w_guard_run = r_guard_run;
`else
    localparam logic GUARD_ON = 1'b0;

    assign w_guard_run = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
            r_frame   <= '0;
            r_hum_int <= '0;
            r_hum_dec <= '0;
            r_tmp_int <= '0;
            r_tmp_dec <= '0;
            r_csum_ok <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_cnt   <= w_cnt_now;

            case (r_state)
                S_IDLE: begin
                    r_oe   <= 1'b0;
                    r_busy <= w_guard_run;
                    if (start && !w_guard_run) begin
                        r_state   <= S_START_LOW;
                        r_cnt     <= '0;
                        r_oe      <= 1'b1;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= '0;
                    end
                end
                S_START_LOW: begin
                    if (w_cnt_now == CNT_W'(START_LOW_US)) begin
                        r_state <= S_WAIT_ACK;
                        r_cnt   <= '0;
                        r_oe    <= 1'b0;
                    end
                end
                S_WAIT_ACK: begin
                    if (w_fall) begin
                        r_state <= S_ACK_LOW;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                        r_cnt   <= '0;
                    end
                end
                S_ACK_LOW: begin
                    if (w_rise) begin
                        r_state <= S_ACK_HIGH;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                        r_cnt   <= '0;
                    end
                end
                S_ACK_HIGH: begin
                    if (w_fall) begin
                        r_state <= S_BIT_LOW;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                        r_cnt   <= '0;
                    end
                end
                S_BIT_LOW: begin
                    if (w_rise) begin
                        r_state <= S_BIT_HIGH;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                        r_cnt   <= '0;
                    end
                end
                S_BIT_HIGH: begin
                    // High-phase length decides the bit; the edge beats a same-cycle timeout
                    if (w_fall) begin
                        r_shift   <= {r_shift[N_BITS-2:0], w_bit};
                        r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
                        r_cnt     <= '0;
                        r_state   <= (r_bit_cnt == BCNT_W'(N_BITS - 1)) ? S_DONE : S_BIT_LOW;
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                        r_cnt   <= '0;
                    end
                end
                S_DONE: begin
                    r_frame   <= r_shift;
                    r_hum_int <= r_shift[39:32];
                    r_hum_dec <= r_shift[31:24];
                    r_tmp_int <= r_shift[23:16];
                    r_tmp_dec <= r_shift[15:8];
                    r_csum_ok <= (w_sum == r_shift[7:0]);
                    r_valid   <= 1'b1;
                    r_busy    <= GUARD_ON;
                    r_cnt     <= '0;
                    r_state   <= S_IDLE;
                end
                S_ERR: begin
                    r_error <= 1'b1;
                    r_busy  <= GUARD_ON;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_oe    <= 1'b0;
                end
            endcase
        end
    end

    assign dht_oe      = r_oe;
    assign busy        = r_busy;
    assign data_valid  = r_valid;
    assign error       = r_error;
    assign frame       = r_frame;
    assign hum_int     = r_hum_int;
    assign hum_dec     = r_hum_dec;
    assign tmp_int     = r_tmp_int;
    assign tmp_dec     = r_tmp_dec;
    assign checksum_ok = r_csum_ok;

endmodule

// File: tb/tb_dht11_frame_reader.sv
// Directed bench for dht11_frame_reader with a behavioural DHT11 sensor on the pad (1 cycle = 1 us).
// Define DHT_GUARD_EN for both files to exercise the inter-transaction guard.
`timescale 1ns/1ps
module tb_dht11_frame_reader;

    localparam int unsigned CLK_HZ       = 1000000;
    localparam int unsigned START_LOW_US = 100;
`ifdef DHT_GUARD_EN
    localparam logic EXP_BUSY_POST = 1'b1;
`else
    localparam logic EXP_BUSY_POST = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        s_lvl = 1'b1;
    logic        dht_in;
    logic        dht_oe;
    logic        busy;
    logic        data_valid;
    logic [39:0] frame;
    logic [7:0]  hum_int;
    logic [7:0]  hum_dec;
    logic [7:0]  tmp_int;
    logic [7:0]  tmp_dec;
    logic        checksum_ok;
    logic        error;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_dv   = 0;
    int n_er   = 0;
    int cyc    = 0;
    int dv_cyc = 0;

    dht11_frame_reader #(
        .CLK_HZ       (CLK_HZ),
        .START_LOW_US (START_LOW_US),
        .BIT_THRESH_US(50),
        .TIMEOUT_US   (255),
        .GUARD_MS     (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dht_in     (dht_in),
        .dht_oe     (dht_oe),
        .busy       (busy),
        .data_valid (data_valid),
        .frame      (frame),
        .hum_int    (hum_int),
        .hum_dec    (hum_dec),
        .tmp_int    (tmp_int),
        .tmp_dec    (tmp_dec),
        .checksum_ok(checksum_ok),
        .error      (error)
    );

    // Open-drain pad: host drive wins, otherwise the sensor (or pull-up) sets the level
    assign dht_in = dht_oe ? 1'b0 : s_lvl;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            n_dv   = n_dv + 1;
            dv_cyc = cyc;
        end
        if (error === 1'b1) n_er = n_er + 1;
    end

    task automatic pulse_start();
        int k = 0;
        while (busy !== 1'b0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_wait: busy=%b want 0", busy);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_oe_fall();
        int k = 0;
        while (dht_oe !== 1'b0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Sensor response: ack, then 40 bits MSB first; abort_bit >= 0 stops mid-high of that bit
    task automatic sensor_reply(input logic [39:0] f, input int hi0, input int hi1, input int abort_bit);
        s_lvl = 1'b1;
        repeat (30) @(negedge clk);
        s_lvl = 1'b0;
        repeat (80) @(negedge clk);
        s_lvl = 1'b1;
        repeat (80) @(negedge clk);
        for (int i = 39; i >= 0; i--) begin
            s_lvl = 1'b0;
            repeat (50) @(negedge clk);
            s_lvl = 1'b1;
            if ((39 - i) == abort_bit) begin
                repeat (10) @(negedge clk);
                return;
            end
            repeat (f[i] ? hi1 : hi0) @(negedge clk);
        end
        s_lvl = 1'b0;
        repeat (50) @(negedge clk);
        s_lvl = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (dht_oe !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: oe=%b busy=%b want 0 0", dht_oe, busy);
        end
        n_cmp++;
        if (data_valid !== 1'b0 || error !== 1'b0 || checksum_ok !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: dv=%b err=%b ok=%b want 0 0 0", data_valid, error, checksum_ok);
        end
        n_cmp++;
        if (frame !== 40'h0 || hum_int !== 8'h0 || tmp_int !== 8'h0) begin
            n_bad++;
            $display("FAIL reset_data: frame=%h want 0000000000", frame);
        end
        rst = 1'b0;
    endtask

    task automatic test_frame(input string name, input logic [39:0] f, input logic exp_ok,
                              input int hi0, input int hi1);
        int dv0 = n_dv;
        int len = 0;
        logic busy_bad = 1'b0;
        pulse_start();
        while (dht_oe === 1'b1 && len < 1000) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            len++;
            @(negedge clk);
        end
        n_cmp++;
        if (len != 100 || busy_bad) begin
            n_bad++;
            $display("FAIL %s_start_pulse: oe_len=%0d busy_drop=%b want 100 0", name, len, busy_bad);
        end
        sensor_reply(f, hi0, hi1, -1);
        @(negedge clk);
        n_cmp++;
        if (n_dv != dv0 + 1) begin
            n_bad++;
            $display("FAIL %s_valid_pulse: dv_cycles=%0d want 1", name, n_dv - dv0);
        end
        n_cmp++;
        if (frame !== f) begin
            n_bad++;
            $display("FAIL %s_frame: got %h want %h", name, frame, f);
        end
        n_cmp++;
        if (hum_int !== f[39:32] || hum_dec !== f[31:24] || tmp_int !== f[23:16] || tmp_dec !== f[15:8]) begin
            n_bad++;
            $display("FAIL %s_bytes: got %h %h %h %h want %h %h %h %h", name, hum_int, hum_dec,
                     tmp_int, tmp_dec, f[39:32], f[31:24], f[23:16], f[15:8]);
        end
        n_cmp++;
        if (checksum_ok !== exp_ok) begin
            n_bad++;
            $display("FAIL %s_checksum: got %b want %b", name, checksum_ok, exp_ok);
        end
        n_cmp++;
        if (busy !== EXP_BUSY_POST) begin
            n_bad++;
            $display("FAIL %s_busy_after: got %b want %b", name, busy, EXP_BUSY_POST);
        end
    endtask

    task automatic test_timeout(input logic [39:0] prev_f);
        int c = 0;
        pulse_start();
        wait_oe_fall();
        while (error !== 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
        end
        // 256 us counted in WAIT_ACK, then the one-cycle ERR state registers the pulse
        n_cmp++;
        if (c != 257) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d cycles want 257", c);
        end
        n_cmp++;
        if (frame !== prev_f || checksum_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_hold: frame=%h ok=%b want %h 1", frame, checksum_ok, prev_f);
        end
        @(negedge clk);
        n_cmp++;
        if (error !== 1'b0 || busy !== EXP_BUSY_POST) begin
            n_bad++;
            $display("FAIL timeout_after: err=%b busy=%b want 0 %b", error, busy, EXP_BUSY_POST);
        end
    endtask

    task automatic test_reset_mid();
        int dv0 = n_dv;
        int er0 = n_er;
        pulse_start();
        wait_oe_fall();
        sensor_reply(40'h3700190050, 27, 70, 20);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_busy_before: got %b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (dht_oe !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_immediate: oe=%b busy=%b want 0 0", dht_oe, busy);
        end
        s_lvl = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        n_cmp++;
        if (n_dv != dv0 || n_er != er0) begin
            n_bad++;
            $display("FAIL abort_no_pulse: dv=%0d err=%0d want 0 0", n_dv - dv0, n_er - er0);
        end
        test_frame("after_abort", 40'h2A0B1C0D5E, 1'b1, 27, 70);
    endtask

`ifdef DHT_GUARD_EN
    task automatic test_guard();
        int k = 0;
        logic oe_seen = 1'b0;
        logic busy_low = 1'b0;
        test_frame("pre_guard", 40'h3700190050, 1'b1, 27, 70);
        while (cyc < dv_cyc + 500) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) begin
            if (dht_oe !== 1'b0) oe_seen = 1'b1;
            if (busy !== 1'b1) busy_low = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (oe_seen || busy_low) begin
            n_bad++;
            $display("FAIL guard_ignore: oe_seen=%b busy_low=%b want 0 0", oe_seen, busy_low);
        end
        while (cyc < dv_cyc + 1100) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL guard_expired: busy=%b want 0", busy);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (dht_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL guard_accept: oe=%b want 1", dht_oe);
        end
        wait_oe_fall();
        while (error !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (error !== 1'b1) begin
            n_bad++;
            $display("FAIL guard_cleanup: err=%b want 1", error);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame("basic", 40'h3700190050, 1'b1, 27, 70);
        test_frame("bad_sum", 40'h3700190051, 1'b0, 27, 70);
        test_frame("mixed", 40'h45011A0363, 1'b1, 27, 70);
        test_frame("thresh", 40'h3700190050, 1'b1, 50, 51);
        test_timeout(40'h3700190050);
        test_reset_mid();
`ifdef DHT_GUARD_EN
        test_guard();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dht11_frame_reader.md
Name: dht11_frame_reader

Overview:
- Protocol engine for the DHT11 single-wire sensor. It sits directly upstream of the frame latch and UART path.
- Issues the host start pulse, tracks the sensor response, and times each of the 40 data bits.
- Outputs the assembled frame, the split humidity and temperature bytes, and a checksum verdict, qualified by a one-cycle valid pulse.

Parameters:
- CLK_HZ, 25000000, system clock frequency. The microsecond tick is CLK_HZ/1000000 cycles; it must divide exactly.
- START_LOW_US, 18000, length of the host low pulse in µs.
- BIT_THRESH_US, 50, high-phase length above which a bit reads as 1.
- TIMEOUT_US, 255, maximum length of any single wait phase before an error.
- GUARD_MS, 1000, minimum spacing between transactions. Used only with DHT_GUARD_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset (see Behaviour)
- start  in  1  single-cycle request to begin a read
- dht_in  in  1  raw pad input; asynchronous
- dht_oe  out  1  1 = drive pad low; 0 = release (pull-up gives high)
- busy  out  1  transaction in progress
- data_valid  out  1  one-cycle pulse: the outputs below are updated
- frame  out  40  {hum_int, hum_dec, tmp_int, tmp_dec, checksum}, MSB first
- hum_int, hum_dec, tmp_int, tmp_dec  out  8 each  decoded bytes
- checksum_ok  out  1  1 when (frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8]) mod 256 equals frame[7:0]
- error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset:
  - rst is asynchronous and active-high; clk is the clock.
  - All outputs go to 0, the state goes to IDLE, and the counters clear.
  - Reset mid-transaction aborts immediately: dht_oe drops to 0 and no data_valid or error is issued.
- Input synchronisation: dht_in passes through a 2-flop synchroniser before any use. Edge detection runs on the synchronised value, which adds 2 cycles of latency.
- Timing base:
  - A free-running prescaler produces us_tick once every CLK_HZ/1e6 cycles.
  - A 16-bit phase counter clears on every state change and increments on us_tick. It saturates at 0xFFFF.
- States:
  - IDLE: busy=0, dht_oe=0. start=1 moves to START_LOW. A start seen in any other state is ignored.
  - START_LOW: dht_oe=1. When the counter reaches START_LOW_US, move to WAIT_ACK with dht_oe=0.
  - WAIT_ACK: wait for the synchronised line to go low, then move to ACK_LOW.
  - ACK_LOW: wait for high, then ACK_HIGH.
  - ACK_HIGH: wait for low, then BIT_LOW.
  - BIT_LOW: wait for high, then BIT_HIGH.
  - BIT_HIGH: on the falling edge, shift in (counter > BIT_THRESH_US) at the LSB of the shift register and increment bit_cnt (6 bits).
    - If bit_cnt becomes 40, go to DONE.
    - Otherwise go to BIT_LOW.
  - DONE, for one cycle:
    - Load frame and the four bytes from the shift register and compute checksum_ok.
    - Pulse data_valid.
    - Return to IDLE.
  - ERR, for one cycle: pulse error, leave frame and the bytes unchanged, return to IDLE.
- Timeout: in WAIT_ACK, ACK_LOW, ACK_HIGH, BIT_LOW and BIT_HIGH, a counter value above TIMEOUT_US goes to ERR.
- Boundaries:
  - An edge and a timeout in the same cycle: the edge wins.
  - A high phase exactly equal to BIT_THRESH_US decodes as 0.
  - Edge pulses shorter than the synchroniser latency are not filtered further; this is acceptable.
- busy=1 in every state except IDLE.
- The outputs hold their last valid frame until the next DONE.

Optional Feature:
- Macro: DHT_GUARD_EN.
- Defined:
  - A guard counter counts GUARD_MS×1000 µs, starting at the exit from DONE or ERR, and also from reset release.
  - While the guard runs, start is ignored and busy stays 1.
  - The guard protects the 1 s minimum sensor interval.
- Undefined: no guard logic is present; start is accepted in any IDLE cycle.

Test Plan (simulate with CLK_HZ=1000000, START_LOW_US=100, i.e. 1 cycle per µs):
- Reset released, start pulse → dht_oe=1 for exactly 100 µs, then 0; busy=1 throughout.
- Sensor model sends ack (80 µs low, 80 µs high) then bytes 0x37,0x00,0x19,0x00,0x50 (0 = 50 µs low + 27 µs high; 1 = 50 µs low + 70 µs high) → data_valid pulse; hum_int=0x37, tmp_int=0x19, checksum_ok=1, frame=0x3700190050.
- Same frame with the last byte 0x51 → data_valid pulse, checksum_ok=0, bytes still decoded.
- Sensor never answers after the start pulse → error pulse at 256 µs into WAIT_ACK; frame keeps its previous value; busy=0 afterwards.
- rst asserted during bit 20 → dht_oe=0 and busy=0 immediately, no data_valid; a new start then completes normally.
- With DHT_GUARD_EN, GUARD_MS=1: start 500 µs after DONE is ignored; start at 1100 µs is accepted.
